// File: rtl/vga_pkg.sv
// vga_pkg: 640x480@60 timing constants shared by the capture path and the
// timing generator, plus the capture lock-state enum.
package vga_pkg;

    localparam int unsigned H_SYNC_PW      = 96;
    localparam int unsigned H_L_PORCH      = 48;
    localparam int unsigned H_VISIBLE      = 640;
    localparam int unsigned H_TOTAL_WIDTH  = 800;
    localparam int unsigned V_SYNC_PW      = 2;
    localparam int unsigned V_T_PORCH      = 33;
    localparam int unsigned V_VISIBLE      = 480;
    localparam int unsigned V_TOTAL_HEIGHT = 525;

    // Source colour trails its internal coordinate by this many clocks.
    localparam int unsigned RGB_LAG = 1;

    localparam int unsigned CNT_W = 10;

    typedef enum logic [1:0] {
        StSearch,
        StMeasure,
        StLocked
    } cap_state_e;

endpackage

// File: rtl/vga_sync_checker.sv
// vga_sync_checker: edge detection on the registered syncs, h/v position
// counters and timing-violation detection.
// Ports:
//   clk_vga, rst_n_vga : pixel clock, async active-low reset
//   hs_s1, vs_s1       : syncs after the input register stage
//   h_cnt, v_cnt       : position of the current S1 sample (combinational)
//   vs_fall            : vs falling edge seen in the current S1 sample
//   sync_err           : any timing violation in the current S1 sample
module vga_sync_checker
    import vga_pkg::*;
#(
    parameter int unsigned HSyncPw = H_SYNC_PW,
    parameter int unsigned HTotal  = H_TOTAL_WIDTH,
    parameter int unsigned VSyncPw = V_SYNC_PW,
    parameter int unsigned VTotal  = V_TOTAL_HEIGHT
) (
    input  logic             clk_vga,
    input  logic             rst_n_vga,
    input  logic             hs_s1,
    input  logic             vs_s1,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic             vs_fall,
    output logic             sync_err
);

    localparam logic [CNT_W-1:0] HLast  = CNT_W'(HTotal - 1);
    localparam logic [CNT_W-1:0] VLast  = CNT_W'(VTotal - 1);
    localparam logic [CNT_W-1:0] HPw    = CNT_W'(HSyncPw);
    localparam logic [CNT_W-1:0] VPw    = CNT_W'(VSyncPw);
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic             hs_prev, vs_prev;
    logic [CNT_W-1:0] h_cnt_q, v_cnt_q;
    // Set once a reference falling edge has been seen; measurements made
    // before that are meaningless and must not flag errors.
    logic             h_armed_q, v_armed_q;
    logic             hs_fall, hs_rise, vs_rise;

    always_comb begin
        hs_fall = hs_prev & ~hs_s1;
        hs_rise = ~hs_prev & hs_s1;
        vs_fall = vs_prev & ~vs_s1;
        vs_rise = ~vs_prev & vs_s1;

        if (hs_fall) begin
            h_cnt = '0;
        end else if (h_cnt_q == CntMax) begin
            h_cnt = h_cnt_q;
        end else begin
            h_cnt = h_cnt_q + 1'b1;
        end

        v_cnt = v_cnt_q;
        if (hs_fall) begin
            if (vs_fall) begin
                v_cnt = '0;
            end else if (v_cnt_q != CntMax) begin
                v_cnt = v_cnt_q + 1'b1;
            end
        end

        // h_cnt_q / v_cnt_q are the values of the sample before the edge.
        sync_err = (hs_fall & h_armed_q & (h_cnt_q != HLast))
                 | (hs_rise & h_armed_q & (h_cnt != HPw))
                 | (vs_fall & ~hs_fall)
                 | (vs_fall & v_armed_q & (v_cnt_q != VLast))
                 | (vs_rise & v_armed_q & (v_cnt != VPw));
    end

    always_ff @(posedge clk_vga or negedge rst_n_vga) begin
        if (!rst_n_vga) begin
            hs_prev   <= 1'b1;
            vs_prev   <= 1'b1;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            h_armed_q <= 1'b0;
            v_armed_q <= 1'b0;
        end else begin
            hs_prev <= hs_s1;
            vs_prev <= vs_s1;
            h_cnt_q <= h_cnt;
            v_cnt_q <= v_cnt;
            if (hs_fall) h_armed_q <= 1'b1;
            if (vs_fall) v_armed_q <= 1'b1;
        end
    end

endmodule

// File: rtl/vga_capture.sv
// vga_capture: registers a VGA source, checks its timing, locks onto it and
// emits captured pixels with coordinates two clocks after the pins.
// Ports:
//   clk_vga, rst_n_vga         : pixel clock, async active-low reset
//   i_vga_hs/vs, i_vga_r/g/b   : source syncs (active low) and colour
//   o_x, o_y, o_de, o_r/g/b    : captured pixel, coordinates held when !o_de
//   o_frame_start              : pulse with pixel (0,0)
//   o_locked                   : source timing locked
//   o_err, o_err_cnt           : violation pulse, saturating violation count
module vga_capture
    import vga_pkg::*;
#(
    parameter int unsigned HSyncPw  = H_SYNC_PW,
    parameter int unsigned HLPorch  = H_L_PORCH,
    parameter int unsigned HVisible = H_VISIBLE,
    parameter int unsigned HTotal   = H_TOTAL_WIDTH,
    parameter int unsigned VSyncPw  = V_SYNC_PW,
    parameter int unsigned VTPorch  = V_T_PORCH,
    parameter int unsigned VVisible = V_VISIBLE,
    parameter int unsigned VTotal   = V_TOTAL_HEIGHT
) (
    input  logic        clk_vga,
    input  logic        rst_n_vga,
    input  logic        i_vga_hs,
    input  logic        i_vga_vs,
    input  logic [3:0]  i_vga_r,
    input  logic [3:0]  i_vga_g,
    input  logic [3:0]  i_vga_b,
    output logic [10:0] o_x,
    output logic [10:0] o_y,
    output logic        o_de,
    output logic [3:0]  o_r,
    output logic [3:0]  o_g,
    output logic [3:0]  o_b,
    output logic        o_frame_start,
    output logic        o_locked,
    output logic        o_err,
    output logic [7:0]  o_err_cnt
);

    localparam logic [CNT_W-1:0] HVisLo = CNT_W'(HSyncPw + HLPorch + RGB_LAG);
    localparam logic [CNT_W-1:0] HVisHi = CNT_W'(HSyncPw + HLPorch + RGB_LAG + HVisible - 1);
    localparam logic [CNT_W-1:0] VVisLo = CNT_W'(VSyncPw + VTPorch);
    localparam logic [CNT_W-1:0] VVisHi = CNT_W'(VSyncPw + VTPorch + VVisible - 1);

    logic             hs_s1, vs_s1;
    logic [3:0]       r_s1, g_s1, b_s1;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic             vs_fall, sync_err, visible;
    cap_state_e       state_q, state_d;

    vga_sync_checker #(
        .HSyncPw (HSyncPw),
        .HTotal  (HTotal),
        .VSyncPw (VSyncPw),
        .VTotal  (VTotal)
    ) u_checker (
        .clk_vga   (clk_vga),
        .rst_n_vga (rst_n_vga),
        .hs_s1     (hs_s1),
        .vs_s1     (vs_s1),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .vs_fall   (vs_fall),
        .sync_err  (sync_err)
    );

    always_ff @(posedge clk_vga or negedge rst_n_vga) begin
        if (!rst_n_vga) begin
            hs_s1   <= 1'b1;
            vs_s1   <= 1'b1;
            r_s1    <= '0;
            g_s1    <= '0;
            b_s1    <= '0;
            state_q <= StSearch;
        end else begin
            hs_s1   <= i_vga_hs;
            vs_s1   <= i_vga_vs;
            r_s1    <= i_vga_r;
            g_s1    <= i_vga_g;
            b_s1    <= i_vga_b;
            state_q <= state_d;
        end
    end

    // An error always wins over any vs-driven advance.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSearch:  if (!sync_err && vs_fall) state_d = StMeasure;
            StMeasure: begin
                if (sync_err) state_d = StSearch;
                else if (vs_fall) state_d = StLocked;
            end
            StLocked:  if (sync_err) state_d = StSearch;
            default:   state_d = StSearch;
        endcase

        // Gating with sync_err drops o_de in the cycle right after detection.
        visible = (state_q == StLocked) && !sync_err
                && (h_cnt >= HVisLo) && (h_cnt <= HVisHi)
                && (v_cnt >= VVisLo) && (v_cnt <= VVisHi);
    end

    always_ff @(posedge clk_vga or negedge rst_n_vga) begin
        if (!rst_n_vga) begin
            o_x           <= '0;
            o_y           <= '0;
            o_de          <= 1'b0;
            o_r           <= '0;
            o_g           <= '0;
            o_b           <= '0;
            o_frame_start <= 1'b0;
            o_locked      <= 1'b0;
            o_err         <= 1'b0;
            o_err_cnt     <= '0;
        end else begin
            o_de          <= visible;
            o_frame_start <= visible && (h_cnt == HVisLo) && (v_cnt == VVisLo);
            o_locked      <= (state_d == StLocked);
            o_err         <= sync_err;
            if (sync_err && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
            if (visible) begin
                o_x <= {1'b0, h_cnt - HVisLo};
                o_y <= {1'b0, v_cnt - VVisLo};
                o_r <= r_s1;
                o_g <= g_s1;
                o_b <= b_s1;
            end else begin
                o_r <= '0;
                o_g <= '0;
                o_b <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: drives a scaled-down VGA timing stream (with injected
// faults) into vga_capture and checks every output cycle against a
// timestamp-based reference model, plus scenario-level checks.
module tb_vga_capture;

    // Scaled timing so hundreds of frames fit in a short run.
    localparam int HS  = 3;
    localparam int HBP = 2;
    localparam int HV  = 8;
    localparam int HT  = 16;
    localparam int VS  = 2;
    localparam int VBP = 1;
    localparam int VV  = 3;
    localparam int VT  = 8;
    localparam int HLO = HS + HBP + 1;
    localparam int VLO = VS + VBP;

    logic        clk_vga = 1'b0;
    logic        rst_n_vga = 1'b1;
    logic        i_vga_hs = 1'b1;
    logic        i_vga_vs = 1'b1;
    logic [3:0]  i_vga_r = '0, i_vga_g = '0, i_vga_b = '0;
    logic [10:0] o_x, o_y;
    logic        o_de, o_frame_start, o_locked, o_err;
    logic [3:0]  o_r, o_g, o_b;
    logic [7:0]  o_err_cnt;

    vga_capture #(
        .HSyncPw  (HS),
        .HLPorch  (HBP),
        .HVisible (HV),
        .HTotal   (HT),
        .VSyncPw  (VS),
        .VTPorch  (VBP),
        .VVisible (VV),
        .VTotal   (VT)
    ) dut (
        .clk_vga       (clk_vga),
        .rst_n_vga     (rst_n_vga),
        .i_vga_hs      (i_vga_hs),
        .i_vga_vs      (i_vga_vs),
        .i_vga_r       (i_vga_r),
        .i_vga_g       (i_vga_g),
        .i_vga_b       (i_vga_b),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_de          (o_de),
        .o_r           (o_r),
        .o_g           (o_g),
        .o_b           (o_b),
        .o_frame_start (o_frame_start),
        .o_locked      (o_locked),
        .o_err         (o_err),
        .o_err_cnt     (o_err_cnt)
    );

    always #5 clk_vga = ~clk_vga;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Reference model state, indexed by pin cycle.
    int  n_cyc = 0;
    bit  m_ph, m_pv, m_harm, m_varm;
    int  m_thf, m_v, m_st, m_ecnt, m_x, m_y;
    logic [63:0] pipe0 = '0, pipe1 = '0;
    bit  rel_pending = 1'b0;

    // Monitors.
    int de_cnt = 0, err_pulses = 0, fs_cnt = 0;
    logic [33:0] fs_pix = '0;

    function automatic logic [63:0] outs_vec();
        return {18'b0, o_de, o_frame_start, o_locked, o_err, o_err_cnt,
                o_x, o_y, o_r, o_g, o_b};
    endfunction

    function automatic void model_reset();
        m_ph = 1'b1; m_pv = 1'b1; m_harm = 1'b0; m_varm = 1'b0;
        m_thf = 0; m_v = 0; m_st = 0; m_ecnt = 0; m_x = 0; m_y = 0;
    endfunction

    // Expected outputs two clocks after these pin values.
    // m_st: 0 searching, 1 measuring, 2 locked.
    function automatic logic [63:0] model_step(input bit hs, input bit vs,
                                               input logic [3:0] r, input logic [3:0] g,
                                               input logic [3:0] b);
        bit hf, hr, vf, vr, err, de, fs;
        int d, h, vn, nst;
        hf = m_ph && !hs;
        hr = !m_ph && hs;
        vf = m_pv && !vs;
        vr = !m_pv && vs;
        d = n_cyc - m_thf;
        if (d > 1023) d = 1023;
        h = hf ? 0 : d;
        vn = m_v;
        if (hf) vn = vf ? 0 : ((m_v < 1023) ? m_v + 1 : m_v);
        err = (hf && m_harm && d != HT)          // line length
            || (hr && m_harm && h != HS)         // hs width
            || (vf && !hf)                       // alignment
            || (vf && m_varm && m_v != VT - 1)   // frame height
            || (vr && m_varm && vn != VS);       // vs width
        de = (m_st == 2) && !err && h >= HLO && h < HLO + HV && vn >= VLO && vn < VLO + VV;
        fs = de && h == HLO && vn == VLO;
        if (err) nst = 0;
        else if (vf) nst = (m_st == 0) ? 1 : 2;
        else nst = m_st;
        if (err && m_ecnt < 255) m_ecnt++;
        if (de) begin
            m_x = h - HLO;
            m_y = vn - VLO;
        end
        m_st = nst;
        if (hf) begin
            m_thf = n_cyc;
            m_harm = 1'b1;
        end
        if (vf) m_varm = 1'b1;
        m_v = vn;
        m_ph = hs;
        m_pv = vs;
        return {18'b0, de, fs, (nst == 2), err, 8'(m_ecnt), 11'(m_x), 11'(m_y),
                de ? {r, g, b} : 12'h000};
    endfunction

    task automatic cycle(input bit hs, input bit vs, input logic [3:0] r,
                         input logic [3:0] g, input logic [3:0] b);
        @(negedge clk_vga);
        check("outs", outs_vec(), pipe0);
        if (o_de) de_cnt++;
        if (o_err) err_pulses++;
        if (o_frame_start) begin
            fs_cnt++;
            fs_pix = {o_x, o_y, o_r, o_g, o_b};
        end
        pipe0 = pipe1;
        if (rel_pending) begin
            rst_n_vga = 1'b1;
            rel_pending = 1'b0;
        end
        i_vga_hs = hs;
        i_vga_vs = vs;
        i_vga_r = r;
        i_vga_g = g;
        i_vga_b = b;
        if (!rst_n_vga) begin
            model_reset();
            pipe1 = '0;
        end else begin
            pipe1 = model_step(hs, vs, r, g, b);
        end
        n_cyc++;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk_vga);
        #2;
        rst_n_vga = 1'b0;
        #1;
        check("rst_async", outs_vec(), 64'h0);
        model_reset();
        pipe0 = '0;
        pipe1 = '0;
        repeat (cycles) cycle(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        rel_pending = 1'b1;
    endtask

    // kind: 0 clean, 1 short line, 2 short hs pulse, 3 stop before bad_line.
    task automatic run_frame(input int n_lines, input int kind, input int bad_line,
                             input int vs_delay, input bit px0);
        int pos;
        pos = 0;
        for (int l = 0; l < n_lines; l++) begin
            int len, hw;
            if (kind == 3 && l == bad_line) return;
            len = (kind == 1 && l == bad_line) ? HT - 1 : HT;
            hw = (kind == 2 && l == bad_line) ? HS - 1 : HS;
            for (int c = 0; c < len; c++) begin
                bit hs, vs;
                logic [3:0] r, g, b;
                hs = (c >= hw);
                vs = !(pos >= vs_delay && pos < vs_delay + VS * HT);
                r = 4'($urandom);
                g = 4'($urandom);
                b = 4'($urandom);
                if (px0 && l == VLO && c == HLO) begin
                    r = 4'h5;
                    g = 4'hA;
                    b = 4'h3;
                end
                cycle(hs, vs, r, g, b);
                pos++;
            end
        end
    endtask

    task automatic relock_check(input string tag);
        run_frame(VT, 0, 0, 0, 1'b0);
        check({tag, "_lock_after_1vf"}, 64'(o_locked), 64'd0);
        run_frame(VT, 0, 0, 0, 1'b0);
        check({tag, "_lock_after_2vf"}, 64'(o_locked), 64'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ecnt0;
        #1 rst_n_vga = 1'b0;
        #1 check("rst_init", outs_vec(), 64'h0);
        model_reset();
        repeat (3) cycle(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        rel_pending = 1'b1;

        // Nominal lock and capture.
        relock_check("nominal");
        de_cnt = 0;
        fs_cnt = 0;
        run_frame(VT, 0, 0, 0, 1'b1);
        check("de_per_frame", 64'(de_cnt), 64'(HV * VV));
        check("fs_per_frame", 64'(fs_cnt), 64'd1);
        check("pixel00", 64'(fs_pix), {30'b0, 11'd0, 11'd0, 4'h5, 4'hA, 4'h3});
        check("err_cnt_nominal", 64'(o_err_cnt), 64'd0);

        // Reset mid-frame of a locked stream.
        run_frame(VT, 3, 4, 0, 1'b0);
        do_reset(3);
        relock_check("after_rst");

        // One short line while locked.
        err_pulses = 0;
        run_frame(VT, 1, 4, 0, 1'b0);
        check("short_line_pulses", 64'(err_pulses), 64'd1);
        check("short_line_locked", 64'(o_locked), 64'd0);
        check("short_line_cnt", 64'(o_err_cnt), 64'd1);
        relock_check("after_line");

        // One narrow hs pulse.
        err_pulses = 0;
        run_frame(VT, 2, 4, 0, 1'b0);
        check("hs_width_pulses", 64'(err_pulses), 64'd1);
        check("hs_width_cnt", 64'(o_err_cnt), 64'd2);
        check("hs_width_locked", 64'(o_locked), 64'd0);
        relock_check("after_hsw");

        // vs falls 10 clocks after hs.
        err_pulses = 0;
        ecnt0 = int'(o_err_cnt);
        run_frame(VT, 0, 0, 10, 1'b0);
        check("align_locked", 64'(o_locked), 64'd0);
        check("align_pulses", 64'(err_pulses), 64'd2);
        check("align_cnt", 64'(o_err_cnt), 64'(ecnt0 + 2));
        run_frame(VT, 0, 0, 0, 1'b0);

        // Repeated frame-height errors saturate the counter.
        err_pulses = 0;
        for (int i = 0; i < 300; i++) run_frame(VT - 1, 0, 0, 0, 1'b0);
        run_frame(VT, 0, 0, 0, 1'b0);
        check("sat_pulses", 64'(err_pulses), 64'd300);
        check("sat_cnt", 64'(o_err_cnt), 64'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 clk_vga  input  1  pixel clock, 25 MHz; all logic on its rising edge.
REQ-002 rst_n_vga  input  1  reset, asynchronous assert, active-low.
REQ-003 i_vga_hs  input  1  horizontal sync from the 640x480 VGA timing source, low during the sync pulse.
REQ-004 i_vga_vs  input  1  vertical sync, low during the sync pulse, falls in the same clock as i_vga_hs falls.
REQ-005 i_vga_r / i_vga_g / i_vga_b  input  4 each  pixel colour, valid 1 clock after the source's internal coordinate.
REQ-006 o_x  output  11  captured pixel column 0..639.
REQ-007 o_y  output  11  captured pixel row 0..479.
REQ-008 o_de  output  1  high when o_x/o_y/o_r/o_g/o_b carry a visible pixel.
REQ-009 o_r / o_g / o_b  output  4 each  captured colour; 0 when o_de low.
REQ-010 o_frame_start  output  1  one-clock pulse in the cycle o_de first rises for x=0, y=0.
REQ-011 o_locked  output  1  timing lock indicator.
REQ-012 o_err  output  1  one-clock pulse on any timing violation.
REQ-013 o_err_cnt  output  8  violation count, saturating at 255.

Function
REQ-014 All i_vga_* pins SHALL be registered once (stage S1); edge detection SHALL compare S1 with its previous value.
REQ-015 hs falling edge SHALL reset h_cnt (10 bit) to 0; otherwise h_cnt increments, saturating at 1023.
REQ-016 h_cnt SHALL be compared with H_TOTAL-1 = 799 at each hs falling edge; a mismatch SHALL be a line-length error.
REQ-017 At each hs rising edge, h_cnt SHALL equal H_SYNC_PW = 96; otherwise it SHALL be an hs-width error.
REQ-018 v_cnt (10 bit) SHALL increment at each hs falling edge and reset to 0 when vs and hs fall together.
REQ-019 A vs falling edge without a coincident hs falling edge SHALL be an alignment error.
REQ-020 At each vs falling edge, the previous v_cnt SHALL equal 524; otherwise it SHALL be a frame-height error.
REQ-021 At vs rising edge, v_cnt SHALL equal V_SYNC_PW = 2; otherwise it SHALL be a vs-width error.
REQ-022 State machine SEARCH -> MEASURE on the first vs falling edge.
REQ-023 MEASURE -> LOCKED on the next vs falling edge if no error occurred in between.
REQ-024 MEASURE -> SEARCH on any error.
REQ-025 LOCKED -> SEARCH on any error; o_locked SHALL be 1 only in LOCKED.
REQ-026 A pixel is visible when h_cnt is in 145..784 (96+48+1 for source RGB lag), v_cnt is in 35..514 and state is LOCKED.
REQ-027 For a visible pixel, o_x = h_cnt-145 and o_y = v_cnt-35.
REQ-028 o_* SHALL be registered; latency from i_vga_* pin to the corresponding o_* output SHALL be exactly 2 clocks.
REQ-029 o_x/o_y SHALL hold their last value when o_de is low.
REQ-030 Multiple errors in one cycle SHALL produce one o_err pulse and one count increment.
REQ-031 An error in the same cycle as a MEASURE->LOCKED condition SHALL win (-> SEARCH).
REQ-032 o_de SHALL drop in the cycle after the error is detected; no partial-frame suppression beyond that.

Reset
REQ-033 While rst_n_vga is low: state=SEARCH, h_cnt=v_cnt=0, S1 sync regs=1, S1 colour regs=0, and all outputs 0 (o_err_cnt included).
REQ-034 Reset mid-frame SHALL discard lock; relock requires the full SEARCH->MEASURE->LOCKED sequence.

Structure
REQ-035 H_SYNC_PW, H_L_PORCH, H_VISIBLE, H_TOTAL_WIDTH, V_SYNC_PW, V_T_PORCH, V_VISIBLE, V_TOTAL_HEIGHT, the RGB lag (1) and the state enum SHALL live in shared package vga_pkg, used by the timing generator too.
REQ-036 One sub-module vga_sync_checker SHALL hold the counters, edge detection and error flags; the top SHALL hold the FSM and output registers.

Verification
REQ-037 Nominal generator stream from reset release -> o_locked rises at the 2nd vs fall; each locked frame gives exactly 307200 o_de cycles; the pixel driven at source (0,0)=R5,G A,B 3 appears at o_x=0, o_y=0 two clocks later with o_frame_start=1.
REQ-038 One line of 799 clocks while locked -> o_err pulse, o_locked=0, o_err_cnt=1; relock after two further vs falls.
REQ-039 One hs pulse 95 clocks wide -> o_err once, o_err_cnt increments by 1, state SEARCH.
REQ-040 rst_n_vga pulsed low at line 200 of a locked frame -> all outputs 0 asynchronously; o_locked returns after 2 vs falls.
REQ-041 300 injected frame-height errors (524-line frames) -> o_err_cnt stops at 255.
REQ-042 vs falling 10 clocks after hs falls -> alignment error, o_locked=0.
